// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bundle between the datapath and pipe_ctrl.
//   Datapath -> controller : fetch_valid, id_rs1, id_rs2, id_multicycle,
//                            ex_rd, ex_is_load, ex_branch_taken
//   Controller -> datapath : pc_en, if_id_en, id_ex_en, ex_wb_en,
//                            bubble_ex, flush_id, vld_id, vld_ex, vld_wb,
//                            state (2b), mc_cnt (4b)
// master = datapath side, slave = controller side.
interface pipe_ctrl_if #(
  parameter int REG_W = 5
);
  logic             fetch_valid;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_multicycle;
  logic [REG_W-1:0] ex_rd;
  logic             ex_is_load;
  logic             ex_branch_taken;

  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_wb_en;
  logic             bubble_ex;
  logic             flush_id;
  logic             vld_id;
  logic             vld_ex;
  logic             vld_wb;
  logic [1:0]       state;
  logic [3:0]       mc_cnt;

  modport master (
    output fetch_valid, id_rs1, id_rs2, id_multicycle, ex_rd, ex_is_load,
           ex_branch_taken,
    input  pc_en, if_id_en, id_ex_en, ex_wb_en, bubble_ex, flush_id,
           vld_id, vld_ex, vld_wb, state, mc_cnt
  );

  modport slave (
    input  fetch_valid, id_rs1, id_rs2, id_multicycle, ex_rd, ex_is_load,
           ex_branch_taken,
    output pc_en, if_id_en, id_ex_en, ex_wb_en, bubble_ex, flush_id,
           vld_id, vld_ex, vld_wb, state, mc_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Stall/flush controller for a 4-stage IF/ID/EX/WB pipeline.
// Handles load-use bubbles, taken-branch flushes and multicycle EX ops
// that hold the whole pipe for MC_LAT cycles.
// Ports:
//   clock - single clock, rising edge
//   reset - synchronous, active-high
//   bus   - pipe_ctrl_if.slave (hazard inputs in, stage enables and
//           registered stage-valid / state / mc_cnt out)
module pipe_ctrl #(
  parameter int REG_W  = 5,
  parameter int MC_LAT = 4   // legal 2..15
) (
  input logic        clock,
  input logic        reset,
  pipe_ctrl_if.slave bus
);

  localparam logic [1:0] S_RUN     = 2'b00;
  localparam logic [1:0] S_MC_BUSY = 2'b01;
  localparam logic [1:0] S_FLUSH   = 2'b10;

  // The cycle that loads the counter is the first EX cycle, so the hold
  // counts MC_LAT-1 down to 0 and the op leaves EX on the zero cycle.
  localparam logic [3:0] MC_LOAD = 4'(MC_LAT - 1);

  logic [1:0]       state_q, state_d;
  logic [3:0]       mc_cnt_q, mc_cnt_d;
  logic             vld_id_q, vld_id_d;
  logic             vld_ex_q, vld_ex_d;
  logic             vld_wb_q, vld_wb_d;

  logic [REG_W-1:0] ex_rd, id_rs1, id_rs2;
  logic             lu_hz, br;
  logic             pc_en, if_id_en, id_ex_en, ex_wb_en, bubble_ex, flush_id;

  assign ex_rd  = bus.ex_rd;
  assign id_rs1 = bus.id_rs1;
  assign id_rs2 = bus.id_rs2;

  // r0 is hard-wired zero, so a load "to r0" never creates a dependency.
  assign lu_hz = vld_id_q & vld_ex_q & bus.ex_is_load & (ex_rd != '0) &
                 ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  assign br    = vld_ex_q & bus.ex_branch_taken;

  // NOTE: every output and next-state value gets a default at the top of
  // this block; any path that skips an assignment would otherwise infer a latch.
  always_comb begin
    pc_en     = 1'b1;
    if_id_en  = 1'b1;
    id_ex_en  = 1'b1;
    ex_wb_en  = 1'b1;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    state_d   = S_RUN;
    mc_cnt_d  = '0;
    vld_id_d  = bus.fetch_valid;
    vld_ex_d  = vld_id_q;
    vld_wb_d  = vld_ex_q;

    if (reset) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_wb_en  = 1'b0;
      bubble_ex = 1'b1;
      flush_id  = 1'b1;
    end else begin
      case (state_q)
        // MC_BUSY with an expired counter is indistinguishable from RUN,
        // which allows back-to-back multicycle ops without a gap cycle.
        S_RUN, S_MC_BUSY: begin
          if (state_q == S_MC_BUSY && mc_cnt_q != '0) begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            id_ex_en = 1'b0;
            ex_wb_en = 1'b0;
            state_d  = S_MC_BUSY;
            mc_cnt_d = mc_cnt_q - 4'd1;
            vld_id_d = vld_id_q;
            vld_ex_d = vld_ex_q;
            vld_wb_d = 1'b0;      // op still in EX; WB must not see it twice
          end else if (br) begin
            flush_id  = 1'b1;
            bubble_ex = 1'b1;
            vld_id_d  = 1'b0;
            vld_ex_d  = 1'b0;
            state_d   = S_FLUSH;
          end else if (lu_hz) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            bubble_ex = 1'b1;
            vld_id_d  = vld_id_q;
            vld_ex_d  = 1'b0;
          end else if (vld_id_q & bus.id_multicycle) begin
            state_d  = S_MC_BUSY;
            mc_cnt_d = MC_LOAD;
          end
        end
        // The instruction behind a taken branch is already squashed, so
        // this cycle only advances; EX holds a bubble and cannot branch.
        S_FLUSH: begin
        end
        default: begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          id_ex_en  = 1'b0;
          ex_wb_en  = 1'b0;
          bubble_ex = 1'b1;
          flush_id  = 1'b1;
          vld_id_d  = 1'b0;
          vld_ex_d  = 1'b0;
          vld_wb_d  = 1'b0;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_RUN;
      mc_cnt_q <= '0;
      vld_id_q <= 1'b0;
      vld_ex_q <= 1'b0;
      vld_wb_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mc_cnt_q <= mc_cnt_d;
      vld_id_q <= vld_id_d;
      vld_ex_q <= vld_ex_d;
      vld_wb_q <= vld_wb_d;
    end
  end

  assign bus.pc_en     = pc_en;
  assign bus.if_id_en  = if_id_en;
  assign bus.id_ex_en  = id_ex_en;
  assign bus.ex_wb_en  = ex_wb_en;
  assign bus.bubble_ex = bubble_ex;
  assign bus.flush_id  = flush_id;
  assign bus.vld_id    = vld_id_q;
  assign bus.vld_ex    = vld_ex_q;
  assign bus.vld_wb    = vld_wb_q;
  assign bus.state     = state_q;
  assign bus.mc_cnt    = mc_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios followed by random
// stimulus, every cycle compared against a pipeline-occupancy model.
module tb_pipe_ctrl;

  localparam int REG_W  = 5;
  localparam int MC_LAT = 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  int   cyc;

  pipe_ctrl_if #(.REG_W(REG_W)) bus ();

  pipe_ctrl #(.REG_W(REG_W), .MC_LAT(MC_LAT)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: which stages hold an instruction, whether EX holds a multicycle
  // op and how many EX cycles it has spent there, and whether the previous
  // cycle squashed ID behind a taken branch.
  bit m_known;
  bit m_id, m_ex, m_wb;
  bit m_ex_mc;
  int m_ex_cycles;
  bit m_after_br;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit fv, input bit mc, input bit ld,
                            input bit brt, input logic [REG_W-1:0] rd,
                            input logic [REG_W-1:0] rs1, input logic [REG_W-1:0] rs2);
    int  left;
    bit  e_pc, e_ifid, e_idex, e_exwb, e_bub, e_fl;
    bit  dep, take_br;
    left = m_ex_mc ? (MC_LAT - m_ex_cycles) : 0;

    if (m_known) begin
      check("vld_id", bus.vld_id, m_id);
      check("vld_ex", bus.vld_ex, m_ex);
      check("vld_wb", bus.vld_wb, m_wb);
      check("state",  bus.state,  m_after_br ? 2 : (m_ex_mc ? 1 : 0));
      check("mc_cnt", bus.mc_cnt, left);
    end

    dep     = !m_after_br && m_id && m_ex && ld && (rd != 0) && (rd == rs1 || rd == rs2);
    take_br = !m_after_br && m_ex && brt;

    if (r) begin
      {e_pc, e_ifid, e_idex, e_exwb, e_bub, e_fl} = 6'b000011;
      m_known = 1; m_id = 0; m_ex = 0; m_wb = 0;
      m_ex_mc = 0; m_ex_cycles = 0; m_after_br = 0;
    end else if (m_ex_mc && left > 0) begin
      {e_pc, e_ifid, e_idex, e_exwb, e_bub, e_fl} = 6'b000000;
      m_ex_cycles++;
      m_wb = 0;
    end else if (take_br) begin
      {e_pc, e_ifid, e_idex, e_exwb, e_bub, e_fl} = 6'b111111;
      m_wb = m_ex; m_ex = 0; m_id = 0;
      m_ex_mc = 0; m_after_br = 1;
    end else if (dep) begin
      {e_pc, e_ifid, e_idex, e_exwb, e_bub, e_fl} = 6'b001110;
      m_wb = m_ex; m_ex = 0;
      m_ex_mc = 0; m_after_br = 0;
    end else begin
      {e_pc, e_ifid, e_idex, e_exwb, e_bub, e_fl} = 6'b111100;
      m_ex_mc = m_id && mc;
      m_ex_cycles = 1;
      m_wb = m_ex; m_ex = m_id; m_id = fv;
      m_after_br = 0;
    end

    check("pc_en",     bus.pc_en,     e_pc);
    check("if_id_en",  bus.if_id_en,  e_ifid);
    check("id_ex_en",  bus.id_ex_en,  e_idex);
    check("ex_wb_en",  bus.ex_wb_en,  e_exwb);
    check("bubble_ex", bus.bubble_ex, e_bub);
    check("flush_id",  bus.flush_id,  e_fl);
  endtask

  // One clock cycle: drive just after the rising edge, compare at the
  // falling edge, then advance to the next rising edge.
  task automatic tick(input bit r, input bit fv, input bit mc, input bit ld, input bit brt,
                      input logic [REG_W-1:0] rd, input logic [REG_W-1:0] rs1,
                      input logic [REG_W-1:0] rs2);
    rst                 = r;
    bus.fetch_valid     = fv;
    bus.id_multicycle   = mc;
    bus.ex_is_load      = ld;
    bus.ex_branch_taken = brt;
    bus.ex_rd           = rd;
    bus.id_rs1          = rs1;
    bus.id_rs2          = rs2;
    @(negedge clk);
    model_step(r, fv, mc, ld, brt, rd, rs1, rs2);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    m_known = 0; m_id = 0; m_ex = 0; m_wb = 0;
    m_ex_mc = 0; m_ex_cycles = 0; m_after_br = 0;
    rst = 1;
    bus.fetch_valid = 0; bus.id_multicycle = 0; bus.ex_is_load = 0;
    bus.ex_branch_taken = 0; bus.ex_rd = '0; bus.id_rs1 = '0; bus.id_rs2 = '0;
    @(posedge clk);
    #1;

    // Reset for two cycles with fetch active, then fill the pipe.
    tick(1, 1, 0, 0, 0, 0, 0, 0);
    tick(1, 1, 0, 0, 0, 0, 0, 0);
    run(3);
    // Load-use on rs2, then the same pattern with ex_rd = r0.
    tick(0, 1, 0, 1, 0, 3, 1, 3);
    run(2);
    tick(0, 1, 0, 1, 0, 0, 0, 0);
    run(1);
    // Multicycle op through EX.
    tick(0, 1, 1, 0, 0, 0, 0, 0);
    run(6);
    // Back-to-back multicycle ops.
    tick(0, 1, 1, 0, 0, 0, 0, 0);
    tick(0, 1, 1, 0, 0, 0, 0, 0);
    tick(0, 1, 1, 0, 0, 0, 0, 0);
    tick(0, 1, 1, 0, 0, 0, 0, 0);
    tick(0, 1, 1, 0, 0, 0, 0, 0);
    run(6);
    // Taken branch together with a load-use hazard.
    tick(0, 1, 0, 1, 1, 3, 3, 3);
    run(3);
    // Reset while mc_cnt is 2.
    tick(0, 1, 1, 0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0, 0, 0, 0);
    tick(1, 1, 0, 0, 0, 0, 0, 0);
    run(4);

    for (int i = 0; i < 4000; i++) begin
      tick($urandom_range(0, 99) < 2,
           $urandom_range(0, 9) < 8,
           $urandom_range(0, 9) < 2,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 99) < 12,
           REG_W'($urandom_range(0, 3)),
           REG_W'($urandom_range(0, 3)),
           REG_W'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter REG_W, default 5, register-specifier width.
REQ-002 SHALL have parameter MC_LAT, default 4, EX occupancy in cycles of a multicycle op; legal range 2..15.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port fetch_valid  input  1  fetch stage presents a valid instruction.
REQ-006 SHALL have ports id_rs1, id_rs2  input  REG_W  source registers of instruction in ID.
REQ-007 SHALL have port id_multicycle  input  1  instruction in ID needs MC_LAT EX cycles.
REQ-008 SHALL have port ex_rd  input  REG_W  destination register of instruction in EX.
REQ-009 SHALL have ports ex_is_load, ex_branch_taken  input  1 each  EX holds a load / a taken branch.
REQ-010 SHALL have ports pc_en, if_id_en, id_ex_en, ex_wb_en  output  1 each  stage-register load enables (ID_EX, EX_WB).
REQ-011 SHALL have ports bubble_ex, flush_id  output  1 each  load NOP into ID_EX / clear IF_ID.
REQ-012 SHALL have ports vld_id, vld_ex, vld_wb  output  1 each  registered stage-valid bits.
REQ-013 SHALL have ports state  output  2 (RUN=00, MC_BUSY=01, FLUSH=10)  and mc_cnt  output  4  remaining hold cycles.

Function
REQ-014 SHALL compute enables/bubble_ex/flush_id combinationally from state, mc_cnt, valid bits and inputs; valid bits, state, mc_cnt registered.
REQ-015 SHALL define lu_hz = vld_id & vld_ex & ex_is_load & (ex_rd != 0) & (ex_rd == id_rs1 | ex_rd == id_rs2).
REQ-016 SHALL define br = vld_ex & ex_branch_taken; priority in RUN: br > lu_hz > multicycle entry > normal advance.
REQ-017 RUN, br: pc_en=1, if_id_en=1, id_ex_en=1, ex_wb_en=1, flush_id=1, bubble_ex=1; next vld_id=0, vld_ex=0, vld_wb=vld_ex; next state FLUSH.
REQ-018 RUN, lu_hz: pc_en=0, if_id_en=0, id_ex_en=1, bubble_ex=1, ex_wb_en=1; next vld_id held, vld_ex=0, vld_wb=vld_ex; state stays RUN (exactly one bubble).
REQ-019 RUN, vld_id & id_multicycle: normal advance; next mc_cnt=MC_LAT-1, state MC_BUSY.
REQ-020 RUN, normal advance: all four enables 1, bubble_ex=0, flush_id=0; next vld_id=fetch_valid, vld_ex=vld_id, vld_wb=vld_ex.
REQ-021 MC_BUSY, mc_cnt != 0: all enables 0, bubble_ex=0, flush_id=0; mc_cnt decrements; vld_id, vld_ex held; next vld_wb=0 (no double writeback).
REQ-022 MC_BUSY, mc_cnt == 0: SHALL behave exactly as RUN for that cycle, including back-to-back multicycle entry and branch/hazard evaluation.
REQ-023 Multicycle op SHALL occupy EX for exactly MC_LAT cycles and reach WB (vld_wb=1) exactly once.
REQ-024 FLUSH: normal advance per REQ-020, ex_branch_taken and lu_hz ignored; next state RUN; lasts exactly one cycle.
REQ-025 ex_rd == 0 SHALL never raise lu_hz; mc_cnt SHALL never wrap below 0.
REQ-026 Unused state encoding 11 SHALL transition to RUN on the next edge with valid bits cleared.

Reset
REQ-027 While reset=1: pc_en, if_id_en, id_ex_en, ex_wb_en = 0; bubble_ex=1, flush_id=1.
REQ-028 On clock edge with reset=1: state=RUN, mc_cnt=0, vld_id=vld_ex=vld_wb=0, from any state incl. mid-MC_BUSY.
REQ-029 First edge after reset deasserts SHALL follow RUN rules with all valid bits 0.

Verification
REQ-030 Reset held 2 cycles, fetch_valid=1 -> enables 0 during reset; vld_id=1 one edge after release, vld_ex=1 after two, vld_wb=1 after three.
REQ-031 vld_id=vld_ex=1, ex_is_load=1, ex_rd=3, id_rs2=3 -> one cycle pc_en=0, if_id_en=0, bubble_ex=1; next cycle vld_ex=0, vld_id=1, normal advance.
REQ-032 Same as REQ-031 with ex_rd=0 -> no stall, bubble_ex=0.
REQ-033 MC_LAT=4, multicycle op in ID -> state MC_BUSY, mc_cnt 3,2,1,0; enables 0 for 3 cycles; op visible at vld_wb=1 for exactly one cycle.
REQ-034 ex_branch_taken=1 with vld_ex=1 and lu_hz true same cycle -> flush_id=1, bubble_ex=1, pc_en=1; state FLUSH then RUN; vld_id=vld_ex=0 after edge.
REQ-035 reset=1 asserted when mc_cnt=2 -> next edge state=RUN, mc_cnt=0, all valid bits 0.
